ascii_operand_sequencer: RTL

Front-end controller for the ASCII adder. Accepts a character stream over a valid/ready handshake and parses two decimal operands of 1–2 digits each, in the form "A+B<Enter>". It time-shares one external ASCII-to-binary converter (2 digit nibbles in, 7-bit binary out, combinational) between operand A and operand B. It then presents both 7-bit binary operands to the downstream adder with a valid/ack handshake.

---
 rtl/ascii_seq_pkg.sv | 25 ++
 rtl/ascii_char_class.sv | 21 ++
 rtl/ascii_operand_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ascii_seq_pkg.sv
// Shared constants and state encoding for the ASCII operand sequencer.
package ascii_seq_pkg;

  localparam int unsigned OP_W = 7;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] CH_PLUS    = 8'h2B;
  localparam logic [7:0] CH_ENTER   = 8'h0D;
  localparam logic [7:0] CH_ESC     = 8'h1B;

  typedef enum logic [3:0] {
    A_D1   = 4'd0,
    A_D2   = 4'd1,
    A_T    = 4'd2,
    CONV_A = 4'd3,
    B_D1   = 4'd4,
    B_D2   = 4'd5,
    B_T    = 4'd6,
    CONV_B = 4'd7,
    OUT    = 4'd8,
    ERR    = 4'd9
  } seq_state_e;

endpackage

// File: rtl/ascii_char_class.sv
// Combinational classifier: decodes one ASCII character into the token
// flags the sequencer cares about, plus the digit value.
module ascii_char_class
  import ascii_seq_pkg::*;
(
  input  logic [7:0] char_data_i,
  output logic       is_digit_o,
  output logic       is_plus_o,
  output logic       is_enter_o,
  output logic       is_esc_o,
  output logic [3:0] nibble_o
);

  assign is_digit_o = (char_data_i >= ASCII_ZERO) && (char_data_i <= ASCII_NINE);
  assign is_plus_o  = (char_data_i == CH_PLUS);
  assign is_enter_o = (char_data_i == CH_ENTER);
  assign is_esc_o   = (char_data_i == CH_ESC);
  // Digits sit at 0x30..0x39, so the low nibble already equals char - '0'.
  assign nibble_o   = char_data_i[3:0];

endmodule

// File: rtl/ascii_operand_sequencer.sv
// Parses "A+B<Enter>" (1-2 digit operands) from a character stream, sharing
// one external ASCII-to-binary converter between A and B.
//
// Handshakes: a character moves when char_valid & char_ready are both high at
// a rising edge. Operands are offered with ops_valid, held until a rising edge
// that sees ops_ack high.
module ascii_operand_sequencer
  import ascii_seq_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         char_valid,
  input  logic [7:0]   char_data,
  output logic         char_ready,
  output logic [W-1:0] conv_AD,
  output logic [W-1:0] conv_AU,
  input  logic [W-1:0] conv_bin,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic         ops_valid,
  input  logic         ops_ack,
  output logic         error,
  output logic         busy,
  output logic [3:0]   dbg_state_o
);

  seq_state_e   state_q, state_d;
  logic [3:0]   tens_q, tens_d;
  logic [3:0]   units_q, units_d;
  logic [W-1:0] op_a_q, op_a_d;
  logic [W-1:0] op_b_q, op_b_d;

  logic       is_digit, is_plus, is_enter, is_esc;
  logic [3:0] nibble;
  logic       accepts_char;
  logic       a_phase;
  logic       is_term;
  logic       xfer;

  ascii_char_class u_class (
    .char_data_i (char_data),
    .is_digit_o  (is_digit),
    .is_plus_o   (is_plus),
    .is_enter_o  (is_enter),
    .is_esc_o    (is_esc),
    .nibble_o    (nibble)
  );

  assign accepts_char = (state_q == A_D1) || (state_q == A_D2) || (state_q == A_T) ||
                        (state_q == B_D1) || (state_q == B_D2) || (state_q == B_T) ||
                        (state_q == ERR);
  assign char_ready   = accepts_char && !rst;
  assign xfer         = char_valid && char_ready;
  assign a_phase      = (state_q == A_D1) || (state_q == A_D2) || (state_q == A_T);
  assign is_term      = a_phase ? is_plus : is_enter;

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    units_d = units_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    case (state_q)
      A_D1, B_D1: begin
        if (xfer) begin
          if (is_digit) begin
            tens_d  = 4'd0;
            units_d = nibble;
            state_d = a_phase ? A_D2 : B_D2;
          end else begin
            state_d = ERR;
          end
        end
      end
      A_D2, B_D2: begin
        if (xfer) begin
          if (is_digit) begin
            tens_d  = units_q;
            units_d = nibble;
            state_d = a_phase ? A_T : B_T;
          end else if (is_term) begin
            state_d = a_phase ? CONV_A : CONV_B;
          end else begin
            state_d = ERR;
          end
        end
      end
      A_T, B_T: begin
        if (xfer) begin
          state_d = is_term ? (a_phase ? CONV_A : CONV_B) : ERR;
        end
      end
      CONV_A: begin
        op_a_d  = conv_bin;
        state_d = B_D1;
      end
      CONV_B: begin
        op_b_d  = conv_bin;
        state_d = OUT;
      end
      OUT: begin
        if (ops_ack) state_d = A_D1;
      end
      ERR: begin
        if (xfer && is_esc) state_d = A_D1;
      end
      default: state_d = A_D1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= A_D1;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  assign conv_AD     = {{(W-4){1'b0}}, tens_q};
  assign conv_AU     = {{(W-4){1'b0}}, units_q};
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign ops_valid   = (state_q == OUT);
  assign error       = (state_q == ERR);
  assign busy        = (state_q != A_D1);
  assign dbg_state_o = state_q;

endmodule
